// File: rtl/fc_hwpe_seq_pkg.sv
// ============================================================================
// fc_hwpe_seq_pkg : shared state encoding and HWPE config-port offsets
// Revision: 1.0
// ============================================================================
`default_nettype none

package fc_hwpe_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_ACQ_REQ  = 4'd1,
        ST_ACQ_RSP  = 4'd2,
        ST_BACKOFF  = 4'd3,
        ST_CFG_REQ  = 4'd4,
        ST_CFG_RSP  = 4'd5,
        ST_TRIG_REQ = 4'd6,
        ST_TRIG_RSP = 4'd7,
        ST_RUN      = 4'd8
    } seq_state_e;

    localparam logic [31:0] OFF_TRIGGER  = 32'h0000_0000;
    localparam logic [31:0] OFF_ACQUIRE  = 32'h0000_0004;
    localparam logic [31:0] OFF_JOB_BASE = 32'h0000_0040;

endpackage

`default_nettype wire

// File: rtl/fc_hwpe_job_fifo.sv
// ============================================================================
// fc_hwpe_job_fifo : pointer-based descriptor FIFO with full/empty flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module fc_hwpe_job_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type         T     = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem_q [DEPTH];
    logic [PTR_W:0]   wptr_q;
    logic [PTR_W:0]   rptr_q;
    logic             push_en;
    logic             pop_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                     (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;
    assign data_o  = mem_q[rptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_en) wptr_q <= wptr_q + 1'b1;
            if (pop_en)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_en) mem_q[wptr_q[PTR_W-1:0]] <= data_i;
    end

endmodule

`default_nettype wire

// File: rtl/fc_hwpe_job_seq.sv
// ============================================================================
// fc_hwpe_job_seq : queues FC job descriptors and sequences them onto the
//                   HWPE config port (acquire, program, trigger, wait event)
// Revision: 1.0
// ============================================================================
`default_nettype none

module fc_hwpe_job_seq
    import fc_hwpe_seq_pkg::*;
#(
    parameter int unsigned N_REGS     = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned TAG_W      = 4,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned RETRY_GAP  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [N_REGS*32-1:0]   job_data_i,
    input  logic [TAG_W-1:0]       job_tag_i,
    output logic                   periph_req_o,
    input  logic                   periph_gnt_i,
    output logic [31:0]            periph_add_o,
    output logic                   periph_wen_o,
    output logic [3:0]             periph_be_o,
    output logic [31:0]            periph_data_o,
    output logic [ID_WIDTH-1:0]    periph_id_o,
    input  logic [31:0]            periph_r_data_i,
    input  logic                   periph_r_valid_i,
    input  logic                   evt_i,
    output logic                   done_valid_o,
    output logic [TAG_W-1:0]       done_tag_o,
    output logic [TIMEOUT_W-1:0]   done_cycles_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned GAP_W = $clog2(RETRY_GAP + 1);

    // Descriptor layout depends on N_REGS/TAG_W, so it is declared per instance.
    typedef struct packed {
        logic [TAG_W-1:0]     tag;
        logic [N_REGS*32-1:0] data;
    } job_desc_t;

    job_desc_t              fifo_wdata, fifo_rdata, desc_q, desc_d;
    logic                   fifo_full, fifo_empty, fifo_pop;
    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [TIMEOUT_W-1:0]   cnt_q, cnt_d;
    logic                   done_valid_q, done_valid_d;
    logic [TAG_W-1:0]       done_tag_q, done_tag_d;
    logic [TIMEOUT_W-1:0]   done_cycles_q, done_cycles_d;
    logic                   err_q, err_d;
    logic                   w_unused;

    // Only the busy flag of the ACQUIRE read is meaningful.
    assign w_unused = ^periph_r_data_i[30:0];

    assign fifo_wdata = '{tag: job_tag_i, data: job_data_i};

    fc_hwpe_job_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (job_desc_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (job_valid_i),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign job_ready_o   = !fifo_full;
    assign busy_o        = (state_q != ST_IDLE) || !fifo_empty;
    assign periph_be_o   = 4'hF;
    assign periph_id_o   = '0;
    assign done_valid_o  = done_valid_q;
    assign done_tag_o    = done_tag_q;
    assign done_cycles_o = done_cycles_q;
    assign err_o         = err_q;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        gap_d         = gap_q;
        cnt_d         = cnt_q;
        desc_d        = desc_q;
        done_valid_d  = 1'b0;
        done_tag_d    = done_tag_q;
        done_cycles_d = done_cycles_q;
        err_d         = err_q;
        fifo_pop      = 1'b0;
        periph_req_o  = 1'b0;
        periph_add_o  = '0;
        periph_wen_o  = 1'b0;
        periph_data_o = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    desc_d   = fifo_rdata;
                    state_d  = ST_ACQ_REQ;
                end
            end
            ST_ACQ_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = OFF_ACQUIRE;
                periph_wen_o = 1'b1;
                if (periph_gnt_i) state_d = ST_ACQ_RSP;
            end
            ST_ACQ_RSP: begin
                if (periph_r_valid_i) begin
                    if (periph_r_data_i[31]) begin
                        gap_d   = '0;
                        state_d = ST_BACKOFF;
                    end else begin
                        idx_d   = '0;
                        state_d = ST_CFG_REQ;
                    end
                end
            end
            ST_BACKOFF: begin
                if (gap_q == GAP_W'(RETRY_GAP - 1)) state_d = ST_ACQ_REQ;
                else                                gap_d   = gap_q + 1'b1;
            end
            ST_CFG_REQ: begin
                periph_req_o  = 1'b1;
                periph_add_o  = OFF_JOB_BASE + 32'({idx_q, 2'b00});
                periph_data_o = desc_q.data[32*idx_q +: 32];
                if (periph_gnt_i) state_d = ST_CFG_RSP;
            end
            ST_CFG_RSP: begin
                if (periph_r_valid_i) begin
                    if (idx_q == IDX_W'(N_REGS - 1)) begin
                        state_d = ST_TRIG_REQ;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_CFG_REQ;
                    end
                end
            end
            ST_TRIG_REQ: begin
                periph_req_o = 1'b1;
                periph_add_o = OFF_TRIGGER;
                if (periph_gnt_i) state_d = ST_TRIG_RSP;
            end
            ST_TRIG_RSP: begin
                if (periph_r_valid_i) begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A real end-of-job event wins over a same-cycle watchdog expiry.
                if (evt_i) begin
                    done_valid_d  = 1'b1;
                    done_tag_d    = desc_q.tag;
                    done_cycles_d = cnt_q;
                    state_d       = ST_IDLE;
                end else if (&cnt_q) begin
                    done_valid_d  = 1'b1;
                    done_tag_d    = desc_q.tag;
                    done_cycles_d = cnt_q;
                    err_d         = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            gap_q         <= '0;
            cnt_q         <= '0;
            desc_q        <= '0;
            done_valid_q  <= 1'b0;
            done_tag_q    <= '0;
            done_cycles_q <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            gap_q         <= gap_d;
            cnt_q         <= cnt_d;
            desc_q        <= desc_d;
            done_valid_q  <= done_valid_d;
            done_tag_q    <= done_tag_d;
            done_cycles_q <= done_cycles_d;
            err_q         <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fc_hwpe_job_seq.sv
// ============================================================================
// tb_fc_hwpe_job_seq : directed scoreboard bench for fc_hwpe_job_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fc_hwpe_job_seq;

    localparam int N_REGS = 8;
    localparam int TAG_W  = 4;
    localparam int TOW    = 8;
    localparam int GAP    = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  job_valid;
    logic                  job_ready_o;
    logic [N_REGS*32-1:0]  job_data;
    logic [TAG_W-1:0]      job_tag;
    logic                  periph_req_o;
    logic                  periph_gnt;
    logic [31:0]           periph_add_o;
    logic                  periph_wen_o;
    logic [3:0]            periph_be_o;
    logic [31:0]           periph_data_o;
    logic [7:0]            periph_id_o;
    logic [31:0]           periph_r_data;
    logic                  periph_r_valid;
    logic                  evt;
    logic                  done_valid_o;
    logic [TAG_W-1:0]      done_tag_o;
    logic [TOW-1:0]        done_cycles_o;
    logic                  busy_o;
    logic                  err_o;

    always #5 clk = ~clk;

    fc_hwpe_job_seq #(
        .N_REGS     (N_REGS),
        .FIFO_DEPTH (2),
        .TAG_W      (TAG_W),
        .ID_WIDTH   (8),
        .TIMEOUT_W  (TOW),
        .RETRY_GAP  (GAP)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .job_valid_i      (job_valid),
        .job_ready_o      (job_ready_o),
        .job_data_i       (job_data),
        .job_tag_i        (job_tag),
        .periph_req_o     (periph_req_o),
        .periph_gnt_i     (periph_gnt),
        .periph_add_o     (periph_add_o),
        .periph_wen_o     (periph_wen_o),
        .periph_be_o      (periph_be_o),
        .periph_data_o    (periph_data_o),
        .periph_id_o      (periph_id_o),
        .periph_r_data_i  (periph_r_data),
        .periph_r_valid_i (periph_r_valid),
        .evt_i            (evt),
        .done_valid_o     (done_valid_o),
        .done_tag_o       (done_tag_o),
        .done_cycles_o    (done_cycles_o),
        .busy_o           (busy_o),
        .err_o            (err_o)
    );

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [TOW-1:0]   cyc;
        logic             err;
    } done_t;

    txn_t        exp_txn[$];
    done_t       exp_done[$];
    int          evt_q[$];

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          max_gap = 0;
    int          wait_left = 0;
    int          acq_busy_left = 0;
    int          evt_cd = 0;
    int          last_busy_cyc = -1;
    logic [31:0] acq_ok_val = 32'h0;
    bit          rsp_pend = 0, rsp_trig = 0, rsp_cfg = 0, rsp_busy = 0;
    bit          req_seen = 0, stale_evt = 0;
    logic [31:0] rsp_data = '0, hold_add = '0, hold_data = '0;
    logic        hold_wen = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the config-port responder, event generator and done monitor.
    task automatic tick();
        txn_t  e;
        done_t d;
        int    dl;
        @(negedge clk);
        cyc++;
        if (done_valid_o) begin
            if (exp_done.size() == 0) begin
                chk("spurious_done", done_valid_o, 1'b0);
            end else begin
                d = exp_done.pop_front();
                chk("done_tag", done_tag_o, d.tag);
                chk("done_cycles", done_cycles_o, d.cyc);
                chk("done_err", err_o, d.err);
            end
        end
        periph_gnt = 1'b0; periph_r_valid = 1'b0; periph_r_data = '0; evt = 1'b0;
        if (evt_cd > 0) begin
            evt_cd--;
            if (evt_cd == 0) evt = 1'b1;
        end
        if (rsp_pend) begin
            chk("req_drop_after_gnt", periph_req_o, 1'b0);
            periph_r_valid = 1'b1;
            periph_r_data  = rsp_data;
            rsp_pend = 0;
            if (rsp_busy) last_busy_cyc = cyc;
            if (rsp_cfg && stale_evt) begin
                evt = 1'b1;
                stale_evt = 0;
            end
            if (rsp_trig && evt_q.size() != 0) begin
                dl = evt_q.pop_front();
                if (dl >= 0) evt_cd = dl + 1;
            end
        end else if (periph_req_o) begin
            if (!req_seen) begin
                req_seen  = 1;
                hold_add  = periph_add_o;
                hold_wen  = periph_wen_o;
                hold_data = periph_data_o;
                if (periph_add_o == 32'h4 && last_busy_cyc >= 0) begin
                    chk("retry_gap", 64'(cyc - last_busy_cyc), 64'(GAP + 1));
                    last_busy_cyc = -1;
                end
            end else begin
                chk("hold_add", periph_add_o, hold_add);
                chk("hold_wen", periph_wen_o, hold_wen);
                chk("hold_data", periph_data_o, hold_data);
            end
            if (wait_left > 0) begin
                wait_left--;
            end else begin
                periph_gnt = 1'b1;
                req_seen   = 0;
                wait_left  = $urandom_range(max_gap, 0);
                chk("be", periph_be_o, 4'hF);
                chk("id", periph_id_o, 8'h00);
                if (exp_txn.size() == 0) begin
                    chk("spurious_txn", periph_req_o, 1'b0);
                end else begin
                    e = exp_txn.pop_front();
                    chk("txn_add", periph_add_o, e.add);
                    chk("txn_wen", periph_wen_o, e.wen);
                    if (!e.wen) chk("txn_data", periph_data_o, e.data);
                end
                rsp_pend = 1;
                rsp_busy = 0;
                rsp_trig = !periph_wen_o && (periph_add_o == 32'h0);
                rsp_cfg  = !periph_wen_o && (periph_add_o >= 32'h40);
                if (periph_wen_o) begin
                    if (acq_busy_left > 0) begin
                        rsp_data = 32'hFFFF_FFFF;
                        rsp_busy = 1;
                        acq_busy_left--;
                    end else begin
                        rsp_data = acq_ok_val;
                    end
                end else begin
                    rsp_data = '0;
                end
            end
        end
    endtask

    task automatic push_job(input logic [TAG_W-1:0] tag, input int busy_n,
                            input int evt_d, input logic err_e);
        logic [N_REGS*32-1:0] d;
        int    n;
        txn_t  t;
        done_t dn;
        n = 0;
        for (int i = 0; i < N_REGS; i++) d[32*i +: 32] = $urandom;
        while (!job_ready_o && n < 2000) begin
            tick();
            n++;
        end
        chk("push_ready", job_ready_o, 1'b1);
        job_valid = 1'b1; job_data = d; job_tag = tag;
        tick();
        job_valid = 1'b0;
        for (int b = 0; b <= busy_n; b++) begin
            t.add = 32'h4; t.wen = 1'b1; t.data = '0;
            exp_txn.push_back(t);
        end
        for (int i = 0; i < N_REGS; i++) begin
            t.add = 32'h40 + 32'(4 * i); t.wen = 1'b0; t.data = d[32*i +: 32];
            exp_txn.push_back(t);
        end
        t.add = 32'h0; t.wen = 1'b0; t.data = 32'h0;
        exp_txn.push_back(t);
        acq_busy_left += busy_n;
        evt_q.push_back(evt_d);
        dn.tag = tag;
        dn.cyc = (evt_d < 0) ? 8'hFF : 8'(evt_d);
        dn.err = err_e;
        exp_done.push_back(dn);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_o || exp_done.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_done", 64'(exp_done.size()), 64'd0);
        chk("drain_txn", 64'(exp_txn.size()), 64'd0);
        chk("drain_busy", busy_o, 1'b0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; job_valid = 1'b0; job_data = '0; job_tag = '0;
        periph_gnt = 1'b0; periph_r_valid = 1'b0; periph_r_data = '0; evt = 1'b0;
        tick(); tick();
        chk("rst_ready", job_ready_o, 1'b1);
        chk("rst_req", periph_req_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_done_valid", done_valid_o, 1'b0);
        chk("rst_done_tag", done_tag_o, 4'h0);
        chk("rst_done_cycles", done_cycles_o, 8'h00);
        rst_n = 1'b1;
        tick();

        // Single job, immediate grants, event 20 cycles into RUN
        push_job(4'h1, 0, 20, 1'b0);
        chk("acq_latency_c1", periph_req_o, 1'b0);
        tick();
        chk("acq_latency_c2", periph_req_o, 1'b1);
        wait_idle(300);
        repeat (3) tick();
        chk("done_tag_hold", done_tag_o, 4'h1);
        chk("done_cycles_hold", done_cycles_o, 8'd20);

        // ACQUIRE busy twice, then free
        acq_ok_val = 32'h1;
        push_job(4'h2, 2, 7, 1'b0);
        wait_idle(400);
        acq_ok_val = 32'h0;

        // Random grant latency
        max_gap = 5;
        push_job(4'h3, 0, 3, 1'b0);
        wait_idle(800);
        max_gap = 0; wait_left = 0;

        // Back-to-back pushes into a depth-2 FIFO; job 5 gets its event in RUN cycle 0
        push_job(4'h4, 0, 2, 1'b0);
        push_job(4'h5, 0, 0, 1'b0);
        push_job(4'h6, 0, 1, 1'b0);
        chk("fifo_full_ready", job_ready_o, 1'b0);
        chk("fifo_full_busy", busy_o, 1'b1);
        push_job(4'h7, 0, 4, 1'b0);
        wait_idle(1000);

        // Stale event during configuration, then watchdog timeout
        stale_evt = 1;
        push_job(4'h8, 0, -1, 1'b1);
        wait_idle(800);
        chk("err_set", err_o, 1'b1);
        repeat (4) tick();
        chk("err_sticky", err_o, 1'b1);

        // Reset while programming register 2
        push_job(4'h9, 0, 10, 1'b1);
        n = 0;
        while (!(periph_req_o && periph_add_o == 32'h48) && n < 500) begin
            tick();
            n++;
        end
        chk("reach_cfg_req", periph_add_o, 32'h48);
        rst_n = 1'b0;
        periph_gnt = 1'b0;
        #1;
        chk("mid_rst_req", periph_req_o, 1'b0);
        chk("mid_rst_add", periph_add_o, 32'h0);
        chk("mid_rst_busy", busy_o, 1'b0);
        chk("mid_rst_err", err_o, 1'b0);
        chk("mid_rst_ready", job_ready_o, 1'b1);
        chk("mid_rst_done_cycles", done_cycles_o, 8'h00);
        exp_txn.delete(); exp_done.delete(); evt_q.delete();
        acq_busy_left = 0; req_seen = 0; wait_left = 0; evt_cd = 0;
        rsp_pend = 0; last_busy_cyc = -1;
        tick(); tick();
        rst_n = 1'b1;
        // Late response from the aborted transaction
        rsp_pend = 1; rsp_data = 32'h0; rsp_cfg = 0; rsp_trig = 0; rsp_busy = 0;
        tick(); tick();
        chk("post_rst_req", periph_req_o, 1'b0);
        chk("post_rst_busy", busy_o, 1'b0);
        push_job(4'hA, 0, 5, 1'b0);
        wait_idle(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
